// File: rtl/vreg_group_wb_tracker_if.sv
// vreg_group_wb_tracker_if: issue, write-back and retire signals of the register group tracker
interface vreg_group_wb_tracker_if #(parameter int ADDR_WIDTH = 5);
  logic                     issue_valid;
  logic                     issue_ready;
  logic [2:0]               issue_vlmul;
  logic [ADDR_WIDTH-1:0]    issue_addr;
  logic                     wb_valid;
  logic [ADDR_WIDTH-1:0]    wb_addr;
  logic                     done_valid;
  logic [ADDR_WIDTH-1:0]    done_addr;
  logic                     err_seq;
  logic [2**ADDR_WIDTH-1:0] busy_mask;
  logic                     idle;
  modport master (
    output issue_valid, issue_vlmul, issue_addr, wb_valid, wb_addr,
    input  issue_ready, done_valid, done_addr, err_seq, busy_mask, idle
  );
  modport slave (
    input  issue_valid, issue_vlmul, issue_addr, wb_valid, wb_addr,
    output issue_ready, done_valid, done_addr, err_seq, busy_mask, idle
  );
endinterface

// File: rtl/vreg_group_wb_tracker.sv
// vreg_group_wb_tracker: in-order register group FIFO checking write-back beats and retiring groups
module vreg_group_wb_tracker #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  vreg_group_wb_tracker_if.slave bus
);
  localparam int NR = 2**ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] f_addr [DEPTH];
  logic [ADDR_WIDTH-1:0] f_base [DEPTH];
  logic [ADDR_WIDTH-1:0] f_last [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] off, exp_addr, new_base, new_span, new_last;
  logic                  push, hit, pop;
  logic [NR-1:0]         set_mask, clr_mask;
  // expected register is the head base plus beats already consumed of the head group
  always_comb begin
    new_base = bus.issue_vlmul[2] ? bus.issue_addr : bus.issue_addr << bus.issue_vlmul[1:0];
    new_span = bus.issue_vlmul[2] ? '0 : ADDR_WIDTH'((4'd1 << bus.issue_vlmul[1:0]) - 4'd1);
    new_last = new_base + new_span;
    exp_addr = f_base[rd_ptr] + off;
    push     = bus.issue_valid && bus.issue_ready;
    hit      = bus.wb_valid && count != '0 && bus.wb_addr == exp_addr;
    pop      = hit && exp_addr == f_last[rd_ptr];
    clr_mask = hit ? NR'(1) << bus.wb_addr : '0;
  end
  for (genvar i = 0; i < NR; i++) begin : g_set
    assign set_mask[i] = push && (ADDR_WIDTH'(i) - new_base) <= new_span;
  end
  assign bus.issue_ready = count != CW'(DEPTH);
  assign bus.idle        = count == '0;
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr] <= bus.issue_addr;
      f_base[wr_ptr] <= new_base;
      f_last[wr_ptr] <= new_last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      off            <= '0;
      bus.busy_mask  <= '0;
      bus.done_valid <= 1'b0;
      bus.err_seq    <= 1'b0;
      bus.done_addr  <= '0;
    end else begin
      wr_ptr         <= wr_ptr + PW'(push);
      rd_ptr         <= rd_ptr + PW'(pop);
      count          <= count + CW'(push) - CW'(pop);
      off            <= pop ? '0 : off + ADDR_WIDTH'(hit);
      bus.busy_mask  <= (bus.busy_mask & ~clr_mask) | set_mask;
      bus.done_valid <= pop;
      bus.err_seq    <= bus.wb_valid && !hit;
      if (pop) bus.done_addr <= f_addr[rd_ptr];
    end
  end
endmodule
